// File: rtl/set_mode_ctrl.sv
// Time-set controller: scan tick generation, RUN/SET_HOUR/SET_MIN/SET_SEC sequencing,
// field increment strobes with auto-repeat, inactivity timeout and field blink.
module set_mode_ctrl #(
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned REPEAT_DELAY = 32,
    parameter int unsigned REPEAT_RATE  = 8,
    parameter int unsigned TIMEOUT      = 1024,
    parameter int unsigned BLINK_HALF   = 16
) (
    input  logic       clock,
    input  logic       reset,
    output logic       scan_tick,
    input  logic       mode_press,
    input  logic       inc_press,
    input  logic       inc_key_in,
    output logic [1:0] mode,
    output logic       run_en,
    output logic       inc_hour,
    output logic       inc_min,
    output logic       sec_clr,
    output logic       blink
);
    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned HW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
    localparam int unsigned IW = $clog2(TIMEOUT + 1);
    localparam int unsigned BW = $clog2(BLINK_HALF + 1);

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_PRE   = TW'(TICK_DIV - 2);
    localparam logic [HW-1:0] HOLD_FIRE  = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(REPEAT_DELAY + REPEAT_RATE - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt;
    logic [3:0]    sampler, sample_d;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [IW-1:0] idle_cnt;
    logic [BW-1:0] blink_cnt;
    logic          rep_fire, idle_clr, timeout, set_state, mode_change;
    logic          inc_act, hour_d, min_d, clr_d, any_strobe;

    assign mode = state_q;

    // Hold counter cycles REPEAT_DELAY..REPEAT_DELAY+REPEAT_RATE-1 once armed, so it stays
    // bounded and every return to REPEAT_DELAY is a repeat point.
    always_comb begin
        sample_d  = {sampler[2:0], inc_key_in};
        hold_nxt  = '0;
        if (sample_d == 4'b0000)
            hold_nxt = (hold_cnt == HOLD_LAST) ? HOLD_FIRE : hold_cnt + 1'b1;
        set_state = (state_q != RUN);
        rep_fire  = scan_tick && !mode_press && (sample_d == 4'b0000) &&
                    (hold_nxt == HOLD_FIRE) &&
                    ((state_q == SET_HOUR) || (state_q == SET_MIN));
        idle_clr  = mode_press || inc_press || rep_fire;
        timeout   = set_state && scan_tick && !idle_clr && (idle_cnt == IDLE_LAST);
    end

    always_comb begin
        state_d = state_q;
        if (mode_press) begin
            case (state_q)
                RUN:      state_d = SET_HOUR;
                SET_HOUR: state_d = SET_MIN;
                SET_MIN:  state_d = SET_SEC;
                SET_SEC:  state_d = RUN;
            endcase
        end else if (timeout) begin
            state_d = RUN;
        end
    end

    always_comb begin
        inc_act     = (inc_press && !mode_press) || rep_fire;
        hour_d      = inc_act && (state_q == SET_HOUR);
        min_d       = inc_act && (state_q == SET_MIN);
        clr_d       = inc_act && (state_q == SET_SEC);
        any_strobe  = hour_d || min_d || clr_d;
        mode_change = (state_d != state_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            run_en   <= 1'b1;
            inc_hour <= 1'b0;
            inc_min  <= 1'b0;
            sec_clr  <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_en   <= (state_d == RUN);
            inc_hour <= hour_d;
            inc_min  <= min_d;
            sec_clr  <= clr_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_cnt  <= '0;
            scan_tick <= 1'b0;
            sampler   <= 4'b1111;
            hold_cnt  <= '0;
            idle_cnt  <= '0;
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else begin
            tick_cnt  <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
            scan_tick <= (tick_cnt == TICK_PRE);

            if (scan_tick)
                sampler <= sample_d;

            if (mode_change)
                hold_cnt <= '0;
            else if (scan_tick)
                hold_cnt <= hold_nxt;

            if ((state_d == RUN) || idle_clr || mode_change)
                idle_cnt <= '0;
            else if (scan_tick)
                idle_cnt <= idle_cnt + 1'b1;

            // A strobe restarts the phase with the field visible for a full half-period.
            if ((state_d == RUN) || mode_change || any_strobe) begin
                blink_cnt <= '0;
                blink     <= 1'b0;
            end else if (scan_tick) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    blink     <= ~blink;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_set_mode_ctrl.sv
// Bench for set_mode_ctrl: a vector table plus timed sequences; each expectation is queued
// with the cycle it is due and compared on the falling edge of that cycle.
module tb_set_mode_ctrl;
    localparam int unsigned TICK_DIV     = 4;
    localparam int unsigned REPEAT_DELAY = 4;
    localparam int unsigned REPEAT_RATE  = 2;
    localparam int unsigned TIMEOUT      = 8;
    localparam int unsigned BLINK_HALF   = 2;

    localparam logic [7:0] M_TICK = 8'b1000_0000;
    localparam logic [7:0] M_MODE = 8'b0110_0000;
    localparam logic [7:0] M_RUN  = 8'b0001_0000;
    localparam logic [7:0] M_HR   = 8'b0000_1000;
    localparam logic [7:0] M_STRB = 8'b0000_1110;
    localparam logic [7:0] M_BLK  = 8'b0000_0001;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       scan_tick, mode_press, inc_press, inc_key_in;
    logic [1:0] mode;
    logic       run_en, inc_hour, inc_min, sec_clr, blink;
    logic [7:0] obs;

    always #5 clock = ~clock;

    set_mode_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE),
        .TIMEOUT     (TIMEOUT),
        .BLINK_HALF  (BLINK_HALF)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .scan_tick (scan_tick),
        .mode_press(mode_press),
        .inc_press (inc_press),
        .inc_key_in(inc_key_in),
        .mode      (mode),
        .run_en    (run_en),
        .inc_hour  (inc_hour),
        .inc_min   (inc_min),
        .sec_clr   (sec_clr),
        .blink     (blink)
    );

    assign obs = {scan_tick, mode, run_en, inc_hour, inc_min, sec_clr, blink};

    typedef struct {
        int unsigned due;
        logic [7:0]  mask;
        logic [7:0]  exp;
        string       name;
    } chk_t;

    typedef struct {
        logic       mp;
        logic       ip;
        logic [1:0] mode;
        logic [2:0] strb;
        string      name;
    } vec_t;

    chk_t        sb[$];
    vec_t        vt[12];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc;

    always @(posedge clock or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [7:0] ov(input logic tk, input logic [1:0] m, input logic r,
                                      input logic [2:0] s, input logic b);
        return {tk, m, r, s, b};
    endfunction

    function automatic logic blink_exp(input int unsigned n);
        return ((n >= 9) && (n <= 16)) || ((n >= 25) && (n <= 26)) || ((n >= 33) && (n <= 40));
    endfunction

    task automatic compare(input string name, input logic [7:0] mask, input logic [7:0] exp);
        checks++;
        if ((obs & mask) !== (exp & mask)) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b exp=%b mask=%b", name, cyc, obs & mask, exp & mask, mask);
        end
    endtask

    task automatic expect_at(input int unsigned due, input string name,
                             input logic [7:0] mask, input logic [7:0] exp);
        sb.push_back('{due: due, mask: mask, exp: exp, name: name});
    endtask

    always @(negedge clock) begin
        for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                compare(sb[i].name, sb[i].mask, sb[i].exp);
                sb.delete(i);
            end
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) @(negedge clock);
    endtask

    task automatic to_tick();
        step(1);
        for (int g = 0; (g < int'(TICK_DIV)) && ((cyc % TICK_DIV) != TICK_DIV - 1); g++)
            step(1);
    endtask

    task automatic drain();
        int unsigned budget = 200;
        while ((sb.size() > 0) && (budget > 0)) begin
            step(1);
            budget--;
        end
        foreach (sb[i]) begin
            checks++;
            errors++;
            $display("FAIL %s due=%0d never compared (cyc=%0d)", sb[i].name, sb[i].due, cyc);
        end
        sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c;
        logic        e;
        mode_press = 1'b0;
        inc_press  = 1'b0;
        inc_key_in = 1'b1;

        vt[0]  = '{1'b1, 1'b0, 2'd1, 3'b000, "mode_to_hour"};
        vt[1]  = '{1'b0, 1'b1, 2'd1, 3'b100, "inc_hour"};
        vt[2]  = '{1'b1, 1'b0, 2'd2, 3'b000, "mode_to_min"};
        vt[3]  = '{1'b0, 1'b1, 2'd2, 3'b010, "inc_min"};
        vt[4]  = '{1'b1, 1'b0, 2'd3, 3'b000, "mode_to_sec"};
        vt[5]  = '{1'b0, 1'b1, 2'd3, 3'b001, "sec_clr"};
        vt[6]  = '{1'b1, 1'b0, 2'd0, 3'b000, "mode_to_run"};
        vt[7]  = '{1'b0, 1'b1, 2'd0, 3'b000, "inc_in_run"};
        vt[8]  = '{1'b1, 1'b0, 2'd1, 3'b000, "mode_to_hour2"};
        vt[9]  = '{1'b1, 1'b1, 2'd2, 3'b000, "mode_and_inc"};
        vt[10] = '{1'b1, 1'b0, 2'd3, 3'b000, "mode_to_sec2"};
        vt[11] = '{1'b1, 1'b0, 2'd0, 3'b000, "mode_to_run2"};

        // reset values and tick cadence
        step(2);
        compare("reset_values", 8'hFF, ov(1'b0, 2'd0, 1'b1, 3'b000, 1'b0));
        reset = 1'b1;
        for (int unsigned k = 1; k <= 12; k++)
            expect_at(k, "tick_cadence", 8'hFF, ov((k % 4) == 3, 2'd0, 1'b1, 3'b000, 1'b0));
        step(12);
        drain();

        // single-cycle press vectors
        for (int i = 0; i < 12; i++) begin
            step(1);
            mode_press = vt[i].mp;
            inc_press  = vt[i].ip;
            expect_at(cyc + 1, vt[i].name, M_MODE | M_RUN | M_STRB,
                      ov(1'b0, vt[i].mode, vt[i].mode == 2'd0, vt[i].strb, 1'b0));
            expect_at(cyc + 2, {vt[i].name, "_one_cycle"}, M_STRB, 8'h00);
            step(1);
            mode_press = 1'b0;
            inc_press  = 1'b0;
            step(8);
        end
        drain();

        // blink phase, strobe hold-off, and blanking in RUN
        to_tick();
        c = cyc;
        for (int unsigned n = 1; n <= 55; n++)
            expect_at(c + n, "blink_phase", M_BLK, {7'b0, blink_exp(n)});
        expect_at(c + 27, "blink_inc_hour", M_HR, M_HR);
        expect_at(c + 47, "blink_back_run", M_MODE | M_RUN, ov(1'b0, 2'd0, 1'b1, 3'b000, 1'b0));
        mode_press = 1'b1;
        step(1);
        mode_press = 1'b0;
        step(25);
        inc_press = 1'b1;
        step(1);
        inc_press = 1'b0;
        step(17);
        mode_press = 1'b1;
        step(3);
        mode_press = 1'b0;
        step(9);
        drain();

        // idle timeout
        to_tick();
        c = cyc;
        expect_at(c + 1,  "to_enter",  M_MODE | M_RUN, ov(1'b0, 2'd1, 1'b0, 3'b000, 1'b0));
        expect_at(c + 32, "to_before", M_MODE | M_RUN, ov(1'b0, 2'd1, 1'b0, 3'b000, 1'b0));
        expect_at(c + 33, "to_expire", M_MODE | M_RUN, ov(1'b0, 2'd0, 1'b1, 3'b000, 1'b0));
        mode_press = 1'b1;
        step(1);
        mode_press = 1'b0;
        step(34);
        drain();

        // timeout restarted by inc_press on the sixth tick
        to_tick();
        c = cyc;
        expect_at(c + 25, "to_inc_hour",   M_HR, M_HR);
        expect_at(c + 33, "to_restarted",  M_MODE | M_RUN, ov(1'b0, 2'd1, 1'b0, 3'b000, 1'b0));
        expect_at(c + 56, "to_before2",    M_MODE | M_RUN, ov(1'b0, 2'd1, 1'b0, 3'b000, 1'b0));
        expect_at(c + 57, "to_expire2",    M_MODE | M_RUN, ov(1'b0, 2'd0, 1'b1, 3'b000, 1'b0));
        mode_press = 1'b1;
        step(1);
        mode_press = 1'b0;
        step(23);
        inc_press = 1'b1;
        step(1);
        inc_press = 1'b0;
        step(34);
        drain();

        // auto-repeat in SET_MIN, then release, then timeout
        to_tick();
        c = cyc;
        for (int unsigned n = 2; n <= 60; n++) begin
            e = (n == 29) || (n == 37) || (n == 45);
            expect_at(c + n, "repeat_min", M_MODE | M_RUN | M_STRB,
                      ov(1'b0, 2'd2, 1'b0, {1'b0, e, 1'b0}, 1'b0));
        end
        expect_at(c + 76, "repeat_pre_timeout", M_MODE, ov(1'b0, 2'd2, 1'b0, 3'b000, 1'b0));
        expect_at(c + 77, "repeat_timeout",     M_MODE | M_RUN, ov(1'b0, 2'd0, 1'b1, 3'b000, 1'b0));
        mode_press = 1'b1;
        step(1);
        inc_key_in = 1'b0;
        step(1);
        mode_press = 1'b0;
        step(44);
        inc_key_in = 1'b1;
        step(32);
        drain();

        // held key in SET_SEC gives no repeat
        to_tick();
        c = cyc;
        for (int unsigned n = 3; n <= 32; n++)
            expect_at(c + n, "sec_hold_no_repeat", M_MODE | M_STRB, ov(1'b0, 2'd3, 1'b0, 3'b000, 1'b0));
        expect_at(c + 33, "sec_hold_timeout", M_MODE | M_RUN, ov(1'b0, 2'd0, 1'b1, 3'b000, 1'b0));
        mode_press = 1'b1;
        step(2);
        inc_key_in = 1'b0;
        step(1);
        mode_press = 1'b0;
        step(31);
        inc_key_in = 1'b1;
        drain();

        // asynchronous reset in the middle of activity
        step(1);
        mode_press = 1'b1;
        step(1);
        mode_press = 1'b0;
        step(2);
        inc_press = 1'b1;
        step(1);
        inc_press = 1'b0;
        compare("pre_reset_strobe", M_MODE | M_HR, ov(1'b0, 2'd1, 1'b0, 3'b100, 1'b0));
        reset = 1'b0;
        #1;
        compare("async_reset", 8'hFF, ov(1'b0, 2'd0, 1'b1, 3'b000, 1'b0));
        step(1);
        reset = 1'b1;
        for (int unsigned k = 1; k <= 8; k++)
            expect_at(k, "tick_after_reset", 8'hFF, ov((k % 4) == 3, 2'd0, 1'b1, 3'b000, 1'b0));
        step(9);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/set_mode_ctrl.md
Name: set_mode_ctrl

Overview:
Time-set controller for the clock display. Generates the scan tick that paces the key debouncers and consumes their single-cycle press pulses (mode, inc). Sequences the RUN/SET_HOUR/SET_MIN/SET_SEC state machine and issues field-increment strobes to the timekeeping counters, with auto-repeat on a held inc key and inactivity timeout back to RUN.

Parameters:
TICK_DIV, 50000, clock cycles per scan_tick (>=2)
REPEAT_DELAY, 32, scan ticks of hold before first auto-repeat strobe (>=1)
REPEAT_RATE, 8, scan ticks between subsequent auto-repeat strobes (>=1)
TIMEOUT, 1024, scan ticks of inactivity in a set state before forced return to RUN (>=1)
BLINK_HALF, 16, scan ticks per blink half-period

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
scan_tick  out  1  one-cycle pacing pulse, drives debouncer time_flag inputs
mode_press  in  1  debounced mode-key press pulse (one cycle)
inc_press  in  1  debounced inc-key press pulse (one cycle)
inc_key_in  in  1  raw inc key level, active-low (0 = pressed)
mode  out  2  0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC
run_en  out  1  high only in RUN; timekeeping counts only when high
inc_hour  out  1  one-cycle hour increment strobe
inc_min  out  1  one-cycle minute increment strobe
sec_clr  out  1  one-cycle seconds clear strobe
blink  out  1  display blank control for the selected field

Behaviour:
- One clock; reset is asynchronous and active-low, all state cleared on reset low regardless of clock.
- Reset values: scan_tick 0, mode 0 (RUN), run_en 1, inc_hour/inc_min/sec_clr 0, blink 0; tick counter, hold sampler (4'b1111), hold/idle counters 0.
- Tick divider: counter 0..TICK_DIV-1, wraps; scan_tick high the single cycle counter == TICK_DIV-1. Free-running in all states.
- FSM on mode_press: RUN->SET_HOUR->SET_MIN->SET_SEC->RUN. Transition registered; mode updates the cycle after the pulse. run_en = (mode==RUN), registered with mode.
- inc_press: SET_HOUR -> inc_hour; SET_MIN -> inc_min; SET_SEC -> sec_clr; RUN -> ignored. Strobe asserted exactly one cycle, one cycle after inc_press.
- Simultaneous mode_press and inc_press: mode transition taken, inc dropped, no strobe.
- Hold detect: on each scan_tick shift inc_key_in into 4-bit sampler; held = sampler==4'b0000. Any non-zero sample clears held and hold counter.
- Auto-repeat (SET_HOUR, SET_MIN only): while held, hold counter increments per scan_tick. Strobe at count == REPEAT_DELAY, then every REPEAT_RATE ticks after. Repeat strobe uses same output as inc_press for current state, one cycle, aligned to cycle after scan_tick. No repeat in SET_SEC or RUN. Hold counter saturates; must not wrap into spurious strobes.
- Repeat strobe coinciding with inc_press: single strobe (OR, not two).
- Mode change clears hold counter; repeat restarts from REPEAT_DELAY in new state.
- Timeout: idle counter increments per scan_tick in set states; cleared by mode_press, inc_press, or any repeat strobe; held at 0 in RUN. Reaching TIMEOUT -> mode RUN next cycle, idle cleared. mode_press same cycle as timeout: mode_press wins (normal transition).
- Blink: in set states toggles every BLINK_HALF scan ticks; forced 0 for one full half-period after any strobe (field visible while adjusting); 0 in RUN; blink phase counter cleared on mode change.
- All outputs registered; no combinational input-to-output paths.

Test Plan:
- Reset/tick: TICK_DIV=4, release reset -> scan_tick pulses at cycles 3,7,11,...; mode=0, run_en=1, all strobes 0; assert reset mid-count -> all outputs back to reset values immediately.
- Mode cycle: four mode_press pulses spaced 10 cycles -> mode 1,2,3,0; run_en 0 for modes 1-3, 1 after return.
- Increments: mode=1, inc_press -> single inc_hour next cycle; mode=3 inc_press -> sec_clr; mode=0 inc_press -> no strobe; mode_press+inc_press same cycle in mode 1 -> mode 2, no inc_hour.
- Auto-repeat: TICK_DIV=4, REPEAT_DELAY=4, REPEAT_RATE=2, mode=2, hold inc_key_in=0 -> held after 4th tick, inc_min on 4th and every 2nd held tick thereafter; release -> strobes stop; same hold in mode 3 -> no strobes.
- Timeout: TIMEOUT=8, enter mode 1, no activity -> mode 0 after 8 scan ticks; repeat with inc_press at tick 6 -> timeout restarts, mode 0 at tick 14.
- Blink: BLINK_HALF=2, mode 1 idle -> blink toggles every 2 ticks; inc_press -> blink 0 for next 2 ticks then resumes; mode 0 -> blink 0.
